prog_loader: RTL and testbench
==============================

// Module: prog_loader
// PURPOSE
//  Boot-time program loader upstream of the RV32I core. Consumes a valid/ready 32-bit word stream of framed
//  records and writes them into IMEM or DMEM through dedicated write ports. Holds the core in reset until
//  a terminator frame is accepted, then releases it. Replaces $readmemh preloading for hardware and system tests.
// PARAMETERS
//  IMEM_DEPTH  256  IMEM size in 32-bit words
//  DMEM_DEPTH  256  DMEM size in 32-bit words (matches RV_DMEM_DEPTH)
// PORTS
//  clk         in   1   single clock
//  rst_n       in   1   synchronous, active-high reset (1 = reset)
//  s_valid     in   1   stream word valid
//  s_ready     out  1   loader accepts word; handshake = s_valid & s_ready
//  s_data      in   32  stream word
//  imem_we     out  1   IMEM write strobe
//  imem_addr   out  clog2(IMEM_DEPTH)  IMEM word address
//  dmem_we     out  1   DMEM write strobe
//  dmem_addr   out  clog2(DMEM_DEPTH)  DMEM word address
//  mem_wdata   out  32  write data shared by both memories
//  core_rst    out  1   active-high reset to core; 1 while loading or on error
//  load_done   out  1   sticky: terminator accepted, core released
//  load_err    out  1   sticky: frame error, core held in reset
// BEHAVIOUR
//  Reset values: s_ready=0, imem_we=dmem_we=0, addrs=0, mem_wdata=0, core_rst=1, load_done=0, load_err=0.
//  FSM: HDR -> ADDR -> DATA [-> CSUM] -> HDR ... ; HDR -> DONE on terminator; any state -> ERR on fault.
//  Header word: [31:24] magic (0xA5 = data frame, 0x5A = terminator), [23] target (0 IMEM, 1 DMEM),
//   [22:16] must be 0, [15:0] word count N. Any other magic or nonzero [22:16] -> ERR.
//  ADDR: word = base word address. Check base + N <= DEPTH of target (17-bit compare, no wrap) else ERR.
//  DATA: N words written to base, base+1, ...; N=0 skips DATA and returns to HDR (or CSUM).
//  Write outputs are registered: we/addr/wdata valid the cycle after the data handshake, we pulses 1 cycle.
//  Only the targeted memory's we asserts; never both in the same cycle.
//  s_ready=1 in HDR/ADDR/DATA/CSUM, and 0 in the first cycle after reset and in DONE/ERR; 0 stalls are
//   allowed on s_valid at any word with no effect on state.
//  DONE: core_rst drops to 0 the cycle after the terminator handshake; load_done=1; further words ignored.
//  ERR: load_err=1, core_rst stays 1, no further writes; exit only via rst_n.
//  rst_n mid-frame: aborts frame, pending write strobe is dropped (we=0 next cycle), core_rst=1, back to HDR.
// CONFIGURATION
//  PROG_LOADER_CSUM_EN defined: each data frame ends with one extra CSUM word = XOR of its N data words
//   (0 for N=0); mismatch -> ERR (already-written words remain in memory).
//  Undefined: no CSUM state; DATA returns directly to HDR.
// STRUCTURE
//  prog_loader_pkg: state enum (HDR, ADDR, DATA, CSUM, DONE, ERR), MAGIC_DATA=8'hA5, MAGIC_TERM=8'h5A,
//   header field bit positions, TGT_IMEM/TGT_DMEM constants.
//  No sub-module: single FSM plus word counter, address counter and XOR accumulator.
// TESTING
//  1. Hdr 0xA5000004, addr 0, 4 words 0x11..0x44, term 0x5A000000 -> imem[0..3] written, core_rst 0, load_done 1.
//  2. DMEM frame 0xA5800002 base 254 (DMEM_DEPTH 256), words 0xFE23,0x1 -> dmem[254]=0xFE23, dmem[255]=1.
//  3. Base 255 with N=2 -> load_err=1, no write strobe, core_rst stays 1.
//  4. Header 0xC3000001 -> ERR; subsequent valid words get s_ready=0.
//  5. s_valid toggled every other cycle during 8-word frame -> exactly 8 imem_we pulses, addrs consecutive.
//  6. rst_n pulsed after 2 of 4 data words -> strobes stop, core_rst=1; a fresh full load afterwards completes.
//  (CSUM_EN) correct XOR 0x44 for words 0x11,0x22,0x33,0x44 -> DONE path; wrong CSUM 0x45 -> load_err=1.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: FSM states, header field layout and magic values shared by the loader and its bench.
package prog_loader_pkg;

    typedef enum logic [2:0] {HDR, ADDR, DATA, CSUM, DONE, ERR} state_t;

    localparam logic [7:0] MAGIC_DATA = 8'hA5;
    localparam logic [7:0] MAGIC_TERM = 8'h5A;

    localparam int HDR_MAGIC_HI = 31;
    localparam int HDR_MAGIC_LO = 24;
    localparam int HDR_TGT      = 23;
    localparam int HDR_RSV_HI   = 22;
    localparam int HDR_RSV_LO   = 16;
    localparam int HDR_CNT_HI   = 15;

    localparam logic TGT_IMEM = 1'b0;
    localparam logic TGT_DMEM = 1'b1;

    function automatic logic hdr_valid(input logic [31:0] w);
        return w[HDR_RSV_HI:HDR_RSV_LO] == '0 &&
               (w[HDR_MAGIC_HI:HDR_MAGIC_LO] == MAGIC_DATA || w[HDR_MAGIC_HI:HDR_MAGIC_LO] == MAGIC_TERM);
    endfunction

endpackage

// File: rtl/prog_loader_if.sv
// prog_loader_if: word stream in, IMEM/DMEM write ports and core-reset status out.
interface prog_loader_if #(
    parameter int IMEM_DEPTH = 256,
    parameter int DMEM_DEPTH = 256
);
    localparam int IAW = $clog2(IMEM_DEPTH);
    localparam int DAW = $clog2(DMEM_DEPTH);

    logic           s_valid;
    logic           s_ready;
    logic [31:0]    s_data;
    logic           imem_we;
    logic [IAW-1:0] imem_addr;
    logic           dmem_we;
    logic [DAW-1:0] dmem_addr;
    logic [31:0]    mem_wdata;
    logic           core_rst;
    logic           load_done;
    logic           load_err;

    modport master (
        output s_valid, s_data,
        input  s_ready, imem_we, imem_addr, dmem_we, dmem_addr, mem_wdata, core_rst, load_done, load_err
    );

    modport slave (
        input  s_valid, s_data,
        output s_ready, imem_we, imem_addr, dmem_we, dmem_addr, mem_wdata, core_rst, load_done, load_err
    );
endinterface

// File: rtl/prog_loader.sv
// prog_loader: boot loader writing framed records into IMEM/DMEM, holding the core in reset until a terminator.
// Define PROG_LOADER_CSUM_EN to require a trailing XOR checksum word on every data frame.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int IMEM_DEPTH = 256,
    parameter int DMEM_DEPTH = 256
) (
    input  logic         clk,
    input  logic         rst_n,
    prog_loader_if.slave bus
);
    localparam int IAW = $clog2(IMEM_DEPTH);
    localparam int DAW = $clog2(DMEM_DEPTH);
    localparam int AW  = IAW > DAW ? IAW : DAW;
    localparam logic [16:0] IMEM_LIM = 17'(IMEM_DEPTH);
    localparam logic [16:0] DMEM_LIM = 17'(DMEM_DEPTH);
`ifdef PROG_LOADER_CSUM_EN
    localparam state_t FRAME_END = CSUM;
`else
    localparam state_t FRAME_END = HDR;
`endif

    state_t        state, state_nxt;
    logic          armed;
    logic          tgt;
    logic [15:0]   cnt;
    logic [AW-1:0] addr;
    logic          hs;
    logic          base_ok;
`ifdef PROG_LOADER_CSUM_EN
    logic [31:0]   xacc;
`endif

    assign hs = bus.s_valid & bus.s_ready;
    // Base must fit in 16 bits and the whole frame must end at or before the target depth.
    assign base_ok = bus.s_data[31:16] == '0 &&
                     ({1'b0, bus.s_data[15:0]} + {1'b0, cnt}) <= (tgt == TGT_DMEM ? DMEM_LIM : IMEM_LIM);

    // State register.
    always_ff @(posedge clk) begin
        if (rst_n) state <= HDR;
        else       state <= state_nxt;
    end

    // Next-state: only a handshake can move the FSM; DONE and ERR never accept words.
    always_comb begin
        state_nxt = state;
        if (hs)
            case (state)
                HDR:  state_nxt = !hdr_valid(bus.s_data) ? ERR :
                                  bus.s_data[HDR_MAGIC_HI:HDR_MAGIC_LO] == MAGIC_TERM ? DONE : ADDR;
                ADDR: state_nxt = !base_ok ? ERR : cnt == '0 ? FRAME_END : DATA;
                DATA: state_nxt = cnt == 16'd1 ? FRAME_END : DATA;
`ifdef PROG_LOADER_CSUM_EN
                CSUM: state_nxt = bus.s_data == xacc ? HDR : ERR;
`endif
                default: state_nxt = state;
            endcase
    end

    // Status outputs; armed keeps s_ready low for the first cycle out of reset.
    always_comb begin
        bus.s_ready   = armed && (state == HDR || state == ADDR || state == DATA || state == CSUM);
        bus.core_rst  = state != DONE;
        bus.load_done = state == DONE;
        bus.load_err  = state == ERR;
    end

    // Frame bookkeeping and registered memory write port.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            armed         <= 1'b0;
            tgt           <= TGT_IMEM;
            cnt           <= '0;
            addr          <= '0;
            bus.imem_we   <= 1'b0;
            bus.dmem_we   <= 1'b0;
            bus.imem_addr <= '0;
            bus.dmem_addr <= '0;
            bus.mem_wdata <= '0;
        end else begin
            armed       <= 1'b1;
            bus.imem_we <= hs && state == DATA && tgt == TGT_IMEM;
            bus.dmem_we <= hs && state == DATA && tgt == TGT_DMEM;
            if (hs && state == HDR) begin
                tgt <= bus.s_data[HDR_TGT];
                cnt <= bus.s_data[HDR_CNT_HI:0];
            end
            if (hs && state == ADDR) addr <= bus.s_data[AW-1:0];
            if (hs && state == DATA) begin
                cnt           <= cnt - 16'd1;
                addr          <= addr + AW'(1);
                bus.mem_wdata <= bus.s_data;
                if (tgt == TGT_DMEM) bus.dmem_addr <= addr[DAW-1:0];
                else                 bus.imem_addr <= addr[IAW-1:0];
            end
        end
    end

`ifdef PROG_LOADER_CSUM_EN
    // Running XOR of the current frame's data words.
    always_ff @(posedge clk) begin
        if (rst_n)                   xacc <= '0;
        else if (hs && state == HDR)  xacc <= '0;
        else if (hs && state == DATA) xacc <= xacc ^ bus.s_data;
    end
`endif

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed frames; expected writes queued at stimulus time, checked by a write monitor.
module tb_prog_loader;
    import prog_loader_pkg::*;

    typedef struct packed {
        logic        dm;
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   wcount = 0;
    wr_t  sb[$];

    prog_loader_if #(.IMEM_DEPTH(256), .DMEM_DEPTH(256)) bus();

    prog_loader #(.IMEM_DEPTH(256), .DMEM_DEPTH(256)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        wr_t got;
        wr_t exp;
        if (bus.imem_we || bus.dmem_we) begin
            wcount++;
            got.dm   = bus.dmem_we;
            got.addr = bus.dmem_we ? bus.dmem_addr : bus.imem_addr;
            got.data = bus.mem_wdata;
            if (bus.imem_we && bus.dmem_we) begin
                tests++;
                fails++;
                $display("FAIL both_we: imem_we and dmem_we both 1, required at most one");
            end
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: got dm=%0b addr=%0d data=%h, required no write", got.dm, got.addr, got.data);
            end else begin
                exp = sb.pop_front();
                chk("write", 64'(got), 64'(exp));
            end
        end
    end

    task automatic status(input string tag, input logic rdy, input logic cr, input logic dn, input logic er);
        chk({tag, "_s_ready"}, 64'(bus.s_ready), 64'(rdy));
        chk({tag, "_core_rst"}, 64'(bus.core_rst), 64'(cr));
        chk({tag, "_load_done"}, 64'(bus.load_done), 64'(dn));
        chk({tag, "_load_err"}, 64'(bus.load_err), 64'(er));
    endtask

    task automatic do_reset();
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        rst_n       = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_imem_we", 64'(bus.imem_we), 64'd0);
        chk("rst_dmem_we", 64'(bus.dmem_we), 64'd0);
        chk("rst_imem_addr", 64'(bus.imem_addr), 64'd0);
        chk("rst_dmem_addr", 64'(bus.dmem_addr), 64'd0);
        chk("rst_wdata", 64'(bus.mem_wdata), 64'd0);
        status("rst", 1'b0, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        chk("first_cycle_ready", 64'(bus.s_ready), 64'd0);
        @(negedge clk);
        chk("ready_after_rst", 64'(bus.s_ready), 64'd1);
    endtask

    task automatic send(input logic [31:0] w);
        int n = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = w;
        while (!bus.s_ready && n < 16) begin
            @(negedge clk);
            n++;
        end
        if (!bus.s_ready) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: s_ready 0 for word %h, required 1", w);
        end else begin
            @(negedge clk);
        end
        bus.s_valid = 1'b0;
    endtask

    task automatic frame(input logic [31:0] hdr, input logic [31:0] base, input logic [31:0] w[$],
                         input logic [31:0] cs, input bit gaps);
        send(hdr);
        send(base);
        foreach (w[i]) begin
            sb.push_back({hdr[23], 8'(base + 32'(i)), w[i]});
            send(w[i]);
            if (gaps) @(negedge clk);
        end
`ifdef PROG_LOADER_CSUM_EN
        send(cs);
`else
        if (gaps && cs === 32'hx) @(negedge clk);
`endif
    endtask

    initial begin
        logic [31:0] q1[$];
        logic [31:0] q2[$];
        logic [31:0] q5[$];
        logic [31:0] none[$];
        q1 = {32'h11, 32'h22, 32'h33, 32'h44};
        q2 = {32'hFE23, 32'h1};
        q5 = {32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7, 32'h8};
        bus.s_valid = 1'b0;
        bus.s_data  = '0;

        // 1: basic IMEM load then terminator
        do_reset();
        frame(32'hA500_0004, 32'd0, q1, 32'h44, 1'b0);
        status("t1_pre", 1'b1, 1'b1, 1'b0, 1'b0);
        send(32'h5A00_0000);
        status("t1", 1'b0, 1'b0, 1'b1, 1'b0);
        bus.s_valid = 1'b1;
        bus.s_data  = 32'hA500_0001;
        @(negedge clk);
        chk("t1_done_ignores", 64'(bus.s_ready), 64'd0);
        bus.s_valid = 1'b0;

        // 2: DMEM frame ending exactly at depth, plus empty IMEM frame at base 256
        do_reset();
        frame(32'hA580_0002, 32'd254, q2, 32'hFE22, 1'b0);
        frame(32'hA500_0000, 32'd256, none, 32'h0, 1'b0);
        status("t2_pre", 1'b1, 1'b1, 1'b0, 1'b0);
        send(32'h5A00_0000);
        status("t2", 1'b0, 1'b0, 1'b1, 1'b0);

        // 3: frame overruns IMEM
        do_reset();
        send(32'hA500_0002);
        send(32'd255);
        status("t3", 1'b0, 1'b1, 1'b0, 1'b1);
        repeat (3) @(negedge clk);

        // 4: bad magic, then words are refused
        do_reset();
        send(32'hC300_0001);
        status("t4", 1'b0, 1'b1, 1'b0, 1'b1);
        bus.s_valid = 1'b1;
        bus.s_data  = 32'hA500_0001;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_refused", 64'(bus.s_ready), 64'd0);
        end
        bus.s_valid = 1'b0;

        // 4b: reserved header bits set
        do_reset();
        send(32'hA501_0001);
        status("t4b", 1'b0, 1'b1, 1'b0, 1'b1);

        // 5: 8-word frame with idle gaps between words
        do_reset();
        wcount = 0;
        frame(32'hA500_0008, 32'd16, q5, 32'h8, 1'b1);
        send(32'h5A00_0000);
        @(negedge clk);
        chk("t5_pulses", 64'(wcount), 64'd8);
        status("t5", 1'b0, 1'b0, 1'b1, 1'b0);

        // 6: reset mid-frame drops the in-flight word, then a fresh load completes
        do_reset();
        send(32'hA500_0004);
        send(32'd0);
        sb.push_back({1'b0, 8'd0, 32'hAA});
        send(32'hAA);
        sb.push_back({1'b0, 8'd1, 32'hBB});
        send(32'hBB);
        bus.s_valid = 1'b1;
        bus.s_data  = 32'hCC;
        rst_n       = 1'b1;
        @(negedge clk);
        chk("t6_imem_we", 64'(bus.imem_we), 64'd0);
        chk("t6_dmem_we", 64'(bus.dmem_we), 64'd0);
        status("t6", 1'b0, 1'b1, 1'b0, 1'b0);
        bus.s_valid = 1'b0;
        rst_n       = 1'b0;
        @(negedge clk);
        chk("t6_ready", 64'(bus.s_ready), 64'd1);
        frame(32'hA500_0004, 32'd0, q1, 32'h44, 1'b0);
        send(32'h5A00_0000);
        status("t6_reload", 1'b0, 1'b0, 1'b1, 1'b0);

`ifdef PROG_LOADER_CSUM_EN
        // 7: wrong checksum leaves written words but errors out
        do_reset();
        frame(32'hA500_0004, 32'd0, q1, 32'h45, 1'b0);
        status("t7", 1'b0, 1'b1, 1'b0, 1'b1);
`endif

        repeat (2) @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
